// File: rtl/demux2_pipe.sv
// Registered 1-to-2 demultiplexer: one valid/ready input steered by s into two
// independent one-entry output slots, each with its own valid/ready drain and delivery counter.
module demux2_pipe #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     d,
  input  logic                 s,
  output logic                 y0_valid,
  input  logic                 y0_ready,
  output logic [WIDTH-1:0]     y0,
  output logic                 y1_valid,
  input  logic                 y1_ready,
  output logic [WIDTH-1:0]     y1,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  logic slot_free0, slot_free1;
  logic accept, load0, load1;
  logic drain0, drain1;

  // A slot can take a word when empty or when its current word leaves this cycle.
  assign slot_free0 = !y0_valid || y0_ready;
  assign slot_free1 = !y1_valid || y1_ready;

  // NOTE: in_ready depends only on s and the selected slot, never on in_valid,
  // so the producer may wait for in_ready before raising in_valid without deadlock.
  assign in_ready = s ? slot_free1 : slot_free0;

  assign accept = in_valid && in_ready;
  assign load0  = accept && !s;
  assign load1  = accept &&  s;
  assign drain0 = y0_valid && y0_ready;
  assign drain1 = y1_valid && y1_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_valid <= 1'b0;
      y0       <= '0;
    end else if (load0) begin
      y0_valid <= 1'b1;
      y0       <= d;
    end else if (drain0) begin
      y0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_valid <= 1'b0;
      y1       <= '0;
    end else if (load1) begin
      y1_valid <= 1'b1;
      y1       <= d;
    end else if (drain1) begin
      y1_valid <= 1'b0;
    end
  end

  // Delivery counters wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0) cnt0 <= cnt0 + 1'b1;
      if (drain1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: doc/demux2_pipe.md
Name: demux2_pipe

Overview:
- Registered 1-to-2 demultiplexer: the routing counterpart of the 2:1 datapath select.
- Accepts one WIDTH-bit word per cycle on a valid/ready input channel. Steers the word, selected by s, into one of two independent output holding registers. Each register drains on its own valid/ready channel.
- Placed between a shared producer (e.g. execute/writeback result bus) and two consumers, so a stall on one path does not block the other.
- Keeps per-output transfer counters for debug/perf.

Parameters:
WIDTH, 64, data width of d, y0, y1
CNT_WIDTH, 16, width of each per-output transfer counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  d and s are valid this cycle
in_ready  output  1  demux can accept the word presented this cycle
d  input  WIDTH  input data word
s  input  1  destination select: 0 -> y0 channel, 1 -> y1 channel
y0_valid  output  1  y0 holds an undelivered word
y0_ready  input  1  consumer 0 accepts y0 this cycle
y0  output  WIDTH  output data, channel 0
y1_valid  output  1  y1 holds an undelivered word
y1_ready  input  1  consumer 1 accepts y1 this cycle
y1  output  WIDTH  output data, channel 1
cnt0  output  CNT_WIDTH  number of words delivered on channel 0
cnt1  output  CNT_WIDTH  number of words delivered on channel 1

Behaviour:
Reset:
- Reset is one clock domain; asynchronous assert on rst_n=0, synchronous-to-clk deassert handled by the reset source.
- Reset values: y0_valid=0, y1_valid=0, y0=0, y1=0, cnt0=0, cnt1=0.
- in_ready during reset follows its combinational equation, which evaluates to 1 since both slots are empty.
- Reset mid-transfer discards held words; no word is delivered after reset release unless newly accepted.

Slot state:
- Each output channel is a one-entry slot with two states, EMPTY (valid=0) and FULL (valid=1).
- EMPTY->FULL: accept targeting this slot.
- FULL->EMPTY: drain (valid & ready) with no accept targeting this slot.
- FULL->FULL: drain and accept on the same cycle (new data loaded).

Accept and latency:
- slot_free(k) = !yk_valid | yk_ready.
- in_ready = s ? slot_free(1) : slot_free(0). in_ready is combinational from s, yk_valid and yk_ready; it does not depend on in_valid.
- Accept = in_valid & in_ready. On accept, d is registered into the slot selected by s; that yk_valid is 1 on the next cycle.
- Latency is 1 cycle, input to output.
- Throughput is 1 word/cycle per channel when the consumer holds ready=1.

Output channel rules:
- Non-selected slot is unaffected by an accept.
- While yk_valid=1 and yk_ready=0, yk is held stable.
- Both channels may drain on the same cycle.
- An accept into slot A proceeds while slot B is stalled; no head-of-line blocking.

Select handling:
- s is sampled only when in_valid=1.
- in_valid=0 with any s: no state change except drains.
- s=X with in_valid=1 is a protocol violation; bench asserts it never happens.

Counters:
- cntk increments by 1 on every cycle with yk_valid & yk_ready.
- cntk wraps modulo 2^CNT_WIDTH, with no saturation.
- cnt0 and cnt1 update independently; both may increment on the same cycle.
- Counters are not affected by accepts, only by deliveries.

Data path:
- No arithmetic on d. Width is preserved bit-exact.

Test Plan:
1. Reset: drive rst_n=0 asynchronously mid-cycle with both slots FULL -> y0_valid=y1_valid=0, cnt0=cnt1=0 immediately; in_ready=1 after release.
2. Alternate routing: y0_ready=y1_ready=1; send d=0x11 s=0, 0x22 s=1, 0x33 s=0 on consecutive cycles -> y0=0x11 at cycle+1, y1=0x22 at cycle+2, y0=0x33 at cycle+3; cnt0=2, cnt1=1.
3. Independent stall: hold y1_ready=0, send 0xAA s=1 then 0xBB s=1 -> 0xAA held on y1, in_ready=0 while s=1. Switching to s=0 with 0xCC accepts immediately, and y0=0xCC next cycle. Release y1_ready -> 0xBB accepted and delivered after 0xAA.
4. Simultaneous drain+fill: slot 0 FULL with y0_ready=1 and in_valid=1 s=0 d=0x5 -> in_ready=1, old word delivered, y0=0x5 next cycle, y0_valid stays 1, cnt0 +1.
5. Counter wrap: CNT_WIDTH=4, deliver 17 words on channel 0 -> cnt0=1, cnt1=0.
6. Random: random in_valid/s/d and random yk_ready for 10k cycles -> scoreboard per channel matches input order exactly, no loss or duplication, and yk is stable under backpressure.
